// File: rtl/bt_move_ctrl_if.sv
// Command/position bundle between the UART receiver,
// the move controller and the VGA drawing logic.
interface bt_move_ctrl_if;
  logic [3:0] dir;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [2:0] cmd;
  logic       moving;
  logic       cmd_valid;
  logic       hit_edge;

  modport master (
    output dir,
    input  pos_x, pos_y, cmd, moving,
    input  cmd_valid, hit_edge
  );

  modport slave (
    input  dir,
    output pos_x, pos_y, cmd, moving,
    output cmd_valid, hit_edge
  );
endinterface

// File: rtl/bt_move_ctrl.sv
// Bluetooth command filter/decoder and clamped
// fixed-rate position stepper for the VGA object.
module bt_move_ctrl #(
  parameter int STABLE_CYC = 20000,
  parameter int STEP_DIV   = 1000000,
  parameter int STEP       = 4,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 624,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 464,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240
) (
  input logic           clk,
  input logic           rst,
  bt_move_ctrl_if.slave bus
);

  localparam int SW = $clog2(STABLE_CYC);
  localparam int TW = $clog2(STEP_DIV);

  localparam logic [SW-1:0] S_ACC = SW'(STABLE_CYC - 2);
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYC - 1);
  localparam logic [TW-1:0] T_MAX = TW'(STEP_DIV - 1);

  localparam logic [9:0] STP = 10'(STEP);
  localparam logic [9:0] XMN = 10'(X_MIN);
  localparam logic [9:0] XMX = 10'(X_MAX);
  localparam logic [9:0] YMN = 10'(Y_MIN);
  localparam logic [9:0] YMX = 10'(Y_MAX);
  localparam logic [9:0] XLO = 10'(X_MIN + STEP);
  localparam logic [9:0] XHI = 10'(X_MAX - STEP);
  localparam logic [9:0] YLO = 10'(Y_MIN + STEP);
  localparam logic [9:0] YHI = 10'(Y_MAX - STEP);
  localparam logic [9:0] XI  = 10'(X_INIT);
  localparam logic [9:0] YI  = 10'(Y_INIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } cmd_e;

  logic [3:0]    dir_q, dir_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  cmd_e          cmd_q, cmd_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          cv_q, cv_d;
  logic          he_q, he_d;
  logic          mv_q;
  logic          acc;

  // Accept only a decodable value that just became stable.
  assign acc = (bus.dir == dir_q) && (scnt_q == S_ACC)
            && (dir_q <= 4'd5);

  // Next state: filter, decode, step timer, clamped step.
  always_comb begin
    dir_d  = dir_q;
    scnt_d = scnt_q;
    tcnt_d = tcnt_q;
    cmd_d  = cmd_q;
    x_d    = x_q;
    y_d    = y_q;
    cv_d   = 1'b0;
    he_d   = 1'b0;

    if (bus.dir != dir_q) begin
      dir_d  = bus.dir;
      scnt_d = '0;
    end else if (scnt_q < S_MAX) begin
      scnt_d = scnt_q + 1'b1;
    end

    if (acc) begin
      cv_d   = 1'b1;
      tcnt_d = '0;
      unique case (dir_q)
        4'd0: cmd_d = IDLE;
        4'd1: cmd_d = UP;
        4'd2: cmd_d = DOWN;
        4'd3: cmd_d = LEFT;
        4'd4: cmd_d = RIGHT;
        default: begin
          cmd_d = IDLE;
          x_d   = XI;
          y_d   = YI;
        end
      endcase
    end else if (cmd_q != IDLE) begin
      if (tcnt_q == T_MAX) begin
        tcnt_d = '0;
        unique case (cmd_q)
          UP:
            if (y_q >= YLO) y_d = y_q - STP;
            else begin y_d = YMN; he_d = 1'b1; end
          DOWN:
            if (y_q <= YHI) y_d = y_q + STP;
            else begin y_d = YMX; he_d = 1'b1; end
          LEFT:
            if (x_q >= XLO) x_d = x_q - STP;
            else begin x_d = XMN; he_d = 1'b1; end
          RIGHT:
            if (x_q <= XHI) x_d = x_q + STP;
            else begin x_d = XMX; he_d = 1'b1; end
          default: ;
        endcase
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end else begin
      tcnt_d = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q  <= '0;
      scnt_q <= '0;
      tcnt_q <= '0;
      cmd_q  <= IDLE;
      x_q    <= XI;
      y_q    <= YI;
      cv_q   <= 1'b0;
      he_q   <= 1'b0;
      mv_q   <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      scnt_q <= scnt_d;
      tcnt_q <= tcnt_d;
      cmd_q  <= cmd_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cv_q   <= cv_d;
      he_q   <= he_d;
      mv_q   <= (cmd_d != IDLE);
    end
  end

  assign bus.pos_x     = x_q;
  assign bus.pos_y     = y_q;
  assign bus.cmd       = cmd_q;
  assign bus.moving    = mv_q;
  assign bus.cmd_valid = cv_q;
  assign bus.hit_edge  = he_q;

endmodule

// File: tb/tb_bt_move_ctrl.sv
// Scoreboard bench for bt_move_ctrl with a
// cycle model and directed end-of-phase checks.
module tb_bt_move_ctrl;

  localparam int SC  = 4;
  localparam int SD  = 8;
  localparam int STP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bt_move_ctrl_if bus();

  bt_move_ctrl #(
    .STABLE_CYC(SC),
    .STEP_DIV  (SD),
    .STEP      (STP)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int cmd;
    int mv;
    int cv;
    int he;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cv_cnt = 0;
  int he_cnt = 0;
  int seen3  = 0;

  int m_dq, m_sc, m_cmd, m_x, m_y, m_t, m_cv, m_he;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int d;
    int ny;
    int nx;
    bit take;
    d = int'(bus.dir);
    m_cv = 0;
    m_he = 0;
    if (rst) begin
      m_dq = 0; m_sc = 0; m_t = 0; m_cmd = 0;
      m_x = 320; m_y = 240;
      return;
    end
    take = (d == m_dq) && (m_sc == SC - 2) && (d <= 5);
    if (d != m_dq) begin
      m_dq = d;
      m_sc = 0;
    end else if (m_sc < SC - 1) begin
      m_sc++;
    end
    if (take) begin
      m_cv = 1;
      m_t = 0;
      if (d == 5) begin
        m_cmd = 0; m_x = 320; m_y = 240;
      end else begin
        m_cmd = d;
      end
    end else if (m_cmd != 0) begin
      if (m_t == SD - 1) begin
        m_t = 0;
        nx = m_x;
        ny = m_y;
        case (m_cmd)
          1: ny = m_y - STP;
          2: ny = m_y + STP;
          3: nx = m_x - STP;
          default: nx = m_x + STP;
        endcase
        if (ny < 0)   begin ny = 0;   m_he = 1; end
        if (ny > 464) begin ny = 464; m_he = 1; end
        if (nx < 0)   begin nx = 0;   m_he = 1; end
        if (nx > 624) begin nx = 624; m_he = 1; end
        m_x = nx;
        m_y = ny;
      end else begin
        m_t++;
      end
    end else begin
      m_t = 0;
    end
  endtask

  // Model on each edge, compare DUT 1 time unit later.
  always @(posedge clk) begin
    exp_t e;
    exp_t g;
    model_step();
    e.x = m_x; e.y = m_y; e.cmd = m_cmd;
    e.mv = (m_cmd != 0); e.cv = m_cv; e.he = m_he;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk("pos_x", int'(bus.pos_x), g.x);
    chk("pos_y", int'(bus.pos_y), g.y);
    chk("cmd", int'(bus.cmd), g.cmd);
    chk("moving", int'(bus.moving), g.mv);
    chk("cmd_valid", int'(bus.cmd_valid), g.cv);
    chk("hit_edge", int'(bus.hit_edge), g.he);
    if (bus.cmd_valid) cv_cnt++;
    if (bus.hit_edge) he_cnt++;
    if (bus.cmd == 3'd3) seen3++;
  end

  task automatic hold(int v, int n);
    bus.dir = 4'(v);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    cv_cnt = 0;
    he_cnt = 0;
    seen3  = 0;
  endtask

  initial begin
    bus.dir = 4'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_x", int'(bus.pos_x), 320);
    chk("rst_y", int'(bus.pos_y), 240);
    chk("rst_cmd", int'(bus.cmd), 0);
    rst = 1'b0;

    clr();
    hold(0, 10);
    chk("idle_cv_cnt", cv_cnt, 1);
    chk("idle_x", int'(bus.pos_x), 320);
    chk("idle_mv", int'(bus.moving), 0);

    hold(1, 20);
    chk("up_y", int'(bus.pos_y), 232);
    chk("up_x", int'(bus.pos_x), 320);
    chk("up_cmd", int'(bus.cmd), 1);

    clr();
    hold(3, 2); hold(1, 2); hold(4, 2);
    chk("glitch_no_cv", cv_cnt, 0);
    hold(4, 2);
    chk("glitch_cv_cnt", cv_cnt, 1);
    chk("glitch_cmd", int'(bus.cmd), 4);
    chk("glitch_seen3", seen3, 0);

    clr();
    hold(4, 1300);
    chk("right_clamp_x", int'(bus.pos_x), 624);
    chk("right_hits_ge2", int'(he_cnt >= 2), 1);

    hold(3, 1300);
    chk("left_clamp_x", int'(bus.pos_x), 0);
    hold(1, 1000);
    chk("top_clamp_y", int'(bus.pos_y), 0);
    hold(2, 1000);
    chk("bot_clamp_y", int'(bus.pos_y), 464);

    hold(1, 30);
    clr();
    hold(5, 10);
    chk("ctr_x", int'(bus.pos_x), 320);
    chk("ctr_y", int'(bus.pos_y), 240);
    chk("ctr_cmd", int'(bus.cmd), 0);
    chk("ctr_mv", int'(bus.moving), 0);
    chk("ctr_cv_cnt", cv_cnt, 1);
    clr();
    hold(5, 40);
    chk("ctr_hold_y", int'(bus.pos_y), 240);
    chk("ctr_hold_cv", cv_cnt, 0);
    hold(7, 10);
    chk("bad_val_cv", cv_cnt, 0);
    chk("bad_val_cmd", int'(bus.cmd), 0);

    hold(4, 4 + 8 * 20);
    chk("pre_rst_x", int'(bus.pos_x), 400);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_x", int'(bus.pos_x), 320);
    chk("mid_rst_y", int'(bus.pos_y), 240);
    chk("mid_rst_cmd", int'(bus.cmd), 0);
    chk("mid_rst_cv", int'(bus.cmd_valid), 0);
    chk("mid_rst_he", int'(bus.hit_edge), 0);
    rst = 1'b0;
    hold(4, 20);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
